// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared constants, command codes and FSM states for the ALU sequencer
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_SL  = 3'b011;
  localparam logic [2:0] OP_SR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_ZLE = 3'b111;

  localparam logic [3:0] CMD_MUL = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MADD,
    ST_MSHL,
    ST_DONE
  } state_t;

  // Codes 1001..1111 carry no meaning and are answered with an error response.
  function automatic logic is_reserved(input logic [3:0] code);
    return code[3] && (code != CMD_MUL);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - command and response handshake bundle of the ALU sequencer
interface alu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_code;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_cout;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_code, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_cout, rsp_zero, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_cout, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu16.sv
// rtl/alu16.sv - shared 16-bit combinational ALU driven by the sequencer
module alu16
  import alu_seq_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s,
  output logic        cout,
  output logic        zero
);

  // One result per op; cout is the ADD carry or the SUB borrow, 0 otherwise.
  always_comb begin
    s    = '0;
    cout = 1'b0;
    case (op)
      OP_ADD: {cout, s} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        s    = a - b;
        cout = (a < b);
      end
      OP_NOT: s = ~a;
      OP_SL:  s = (b[15:4] != 12'd0) ? 16'd0 : (a << b[3:0]);
      OP_SR:  s = (b[15:4] != 12'd0) ? 16'd0 : (a >> b[3:0]);
      OP_AND: s = a & b;
      OP_OR:  s = a | b;
      OP_ZLE: s = (a > b) ? (a - b) : 16'd0;
      default: s = '0;
    endcase
  end

  assign zero = (s == 16'd0);

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command-level controller for single ALU ops and shift-and-add multiply
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.slave   bus,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_cout,
  input  logic             alu_zero
);

  state_t           state;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] q_q;
  logic             sticky_q;
  logic [WIDTH-1:0] q_shr;

  // Multiplier is consumed LSB first; shifting it needs no ALU cycle.
  assign q_shr = q_q >> 1;

  // Main FSM: every output is a register, so the ALU inputs for a busy state
  // are loaded on the edge that enters that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      p_q           <= '0;
      m_q           <= '0;
      q_q           <= '0;
      sticky_q      <= 1'b0;
      alu_op        <= OP_ADD;
      alu_a         <= '0;
      alu_b         <= '0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_cout  <= 1'b0;
      bus.rsp_zero  <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            if (!bus.cmd_code[3]) begin
              alu_op <= bus.cmd_code[2:0];
              alu_a  <= bus.cmd_a;
              alu_b  <= bus.cmd_b;
              state  <= ST_EXEC;
            end else if (is_reserved(bus.cmd_code)) begin
              bus.rsp_data  <= '0;
              bus.rsp_cout  <= 1'b0;
              bus.rsp_zero  <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_valid <= 1'b1;
              state         <= ST_DONE;
            end else begin
              p_q      <= '0;
              m_q      <= bus.cmd_a;
              q_q      <= bus.cmd_b;
              sticky_q <= 1'b0;
              if (bus.cmd_b == '0) begin
                bus.rsp_data  <= '0;
                bus.rsp_cout  <= 1'b0;
                bus.rsp_zero  <= 1'b1;
                bus.rsp_err   <= 1'b0;
                bus.rsp_valid <= 1'b1;
                state         <= ST_DONE;
              end else if (bus.cmd_b[0]) begin
                alu_op <= OP_ADD;
                alu_a  <= '0;
                alu_b  <= bus.cmd_a;
                state  <= ST_MADD;
              end else begin
                alu_op <= OP_SL;
                alu_a  <= bus.cmd_a;
                alu_b  <= WIDTH'(1);
                state  <= ST_MSHL;
              end
            end
          end
        end

        ST_EXEC: begin
          bus.rsp_data  <= alu_s;
          bus.rsp_cout  <= alu_cout;
          bus.rsp_zero  <= alu_zero;
          bus.rsp_err   <= 1'b0;
          bus.rsp_valid <= 1'b1;
          alu_op        <= OP_ADD;
          alu_a         <= '0;
          alu_b         <= '0;
          state         <= ST_DONE;
        end

        ST_MADD: begin
          p_q      <= alu_s;
          sticky_q <= sticky_q | alu_cout;
          alu_op   <= OP_SL;
          alu_a    <= m_q;
          alu_b    <= WIDTH'(1);
          state    <= ST_MSHL;
        end

        ST_MSHL: begin
          m_q <= alu_s;
          q_q <= q_shr;
          if (q_shr == '0) begin
            bus.rsp_data  <= p_q;
            bus.rsp_cout  <= sticky_q;
            bus.rsp_zero  <= (p_q == '0);
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            alu_op        <= OP_ADD;
            alu_a         <= '0;
            alu_b         <= '0;
            state         <= ST_DONE;
          end else if (q_shr[0]) begin
            alu_op <= OP_ADD;
            alu_a  <= p_q;
            alu_b  <= alu_s;
            state  <= ST_MADD;
          end else begin
            alu_op <= OP_SL;
            alu_a  <= alu_s;
            alu_b  <= WIDTH'(1);
            state  <= ST_MSHL;
          end
        end

        ST_DONE: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_cout  <= 1'b0;
            bus.rsp_zero  <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with the real ALU attached
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(16)) bus ();

  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_s;
  logic        alu_cout, alu_zero;

  alu_sequencer #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_s    (alu_s),
    .alu_cout (alu_cout),
    .alu_zero (alu_zero)
  );

  alu16 u_alu (
    .op   (alu_op),
    .a    (alu_a),
    .b    (alu_b),
    .s    (alu_s),
    .cout (alu_cout),
    .zero (alu_zero)
  );

  typedef struct {
    logic [15:0] data;
    logic        cout;
    logic        zero;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic stall = 1'b0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: results follow the command rules with plain integer arithmetic.
  // lat counts edges from the negedge before the accept edge to the first
  // negedge where rsp_valid is seen: 2 for a single op, 1 for an immediate
  // answer, 1 + (msb(b)+1) + popcount(b) for a multiply.
  function automatic exp_t model(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int unsigned ia, ib, r, p, hb, pc;
    e.data = 16'd0; e.cout = 1'b0; e.err = 1'b0; e.lat = 1; e.acc = 0;
    ia = a; ib = b;
    if (!code[3]) begin
      e.lat = 2;
      case (code[2:0])
        3'd0: begin r = ia + ib; e.cout = (r > 65535); e.data = 16'(r); end
        3'd1: begin e.data = 16'(ia - ib); e.cout = (ia < ib); end
        3'd2: e.data = 16'(65535 - ia);
        3'd3: e.data = (ib > 15) ? 16'd0 : 16'(ia * (1 << ib));
        3'd4: e.data = (ib > 15) ? 16'd0 : 16'(ia / (1 << ib));
        3'd5: e.data = a & b;
        3'd6: e.data = a | b;
        default: e.data = (ia > ib) ? 16'(ia - ib) : 16'd0;
      endcase
    end else if (code == 4'b1000) begin
      p = 0; hb = 0; pc = 0;
      for (int i = 0; i < 16; i++) begin
        if (b[i]) begin
          r = p + ((ia * (1 << i)) % 65536);
          if (r > 65535) e.cout = 1'b1;
          p = r % 65536;
          hb = i;
          pc++;
        end
      end
      e.data = 16'(p);
      e.lat = (b == 16'd0) ? 1 : 1 + (hb + 1) + pc;
    end else begin
      e.err = 1'b1;
    end
    e.zero = (e.data == 16'd0);
    return e;
  endfunction

  task automatic send(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int n = 0;
    bus.cmd_code  = code;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    while (!bus.cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: cmd_ready stayed 0 for code %0h", code);
      bus.cmd_valid = 1'b0;
      return;
    end
    e = model(code, a, b);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 4'($urandom);
    bus.cmd_a     = 16'($urandom);
    bus.cmd_b     = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_cout, bus.rsp_zero,
             bus.rsp_err, alu_op, alu_a, alu_b}, 64'd0);
  endtask

  // Consumer: random backpressure, forced low while stall is set.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.rsp_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares every cycle a response is held and pops on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: data 0x%0h with empty scoreboard", bus.rsp_data);
        end else begin
          e = sb[0];
          if (!prev_valid) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_cout", bus.rsp_cout, e.cout);
          chk("rsp_zero", bus.rsp_zero, e.zero);
          chk("rsp_err", bus.rsp_err, e.err);
          chk("cmd_ready_busy", bus.cmd_ready, 1'b0);
          chk("alu_idle", {alu_op, alu_a, alu_b}, 64'd0);
          if (bus.rsp_ready) void'(sb.pop_front());
        end
      end
      prev_valid = rst_n && bus.rsp_valid;
    end
  end

  initial begin
    logic [3:0]  code;
    logic [15:0] a, b;
    int          sel;
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 4'd0;
    bus.cmd_a     = 16'd0;
    bus.cmd_b     = 16'd0;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("cmd_ready_after_reset", bus.cmd_ready, 1'b1);

    send({1'b0, OP_SUB}, 16'd5, 16'd7);
    send({1'b0, OP_ZLE}, 16'd3, 16'd3);
    send(CMD_MUL, 16'd3, 16'd5);
    send(CMD_MUL, 16'hFFFF, 16'd3);
    send(CMD_MUL, 16'd7, 16'd0);
    drain();

    stall = 1'b1;
    send(4'b1010, 16'h1234, 16'h5678);
    repeat (12) @(negedge clk);
    stall = 1'b0;
    drain();

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      a = 16'($urandom);
      b = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if (sel < 7)       code = {1'b0, 3'($urandom)};
      else if (sel < 9)  code = CMD_MUL;
      else               code = 4'($urandom_range(9, 15));
      send(code, a, b);
    end
    drain();

    send(CMD_MUL, 16'h1234, 16'h8000);
    repeat (4) @(posedge clk);
    #2;
    chk("mshl_before_reset", {alu_op, alu_b}, {OP_SL, 16'd1});
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_mid_mul");
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("cmd_ready_after_abort", bus.cmd_ready, 1'b1);
    send({1'b0, OP_ADD}, 16'd1, 16'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
